// File: rtl/servile_arb_pkg.sv
// Shared types and helpers for the N-master Wishbone arbiter.
package servile_arb_pkg;

    // Arbiter owns the slave port only while BUSY.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    // Width of an index into n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/servile_rr_picker.sv
// Combinational winner selection: round-robin from last+1, or lowest index.
module servile_rr_picker
    import servile_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_last,
    input  logic          i_rr,
    output logic          o_valid,
    output logic [GW-1:0] o_idx
);

    // Candidate visited at scan offset gi+1 past the last owner.
    logic [GW-1:0] w_cand [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign w_cand[gi] = GW'((32'(i_last) + 32'(gi) + 32'd1) % 32'(N));
    end

    // Scan from the far end down so the nearest requester is written last.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        if (i_rr) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_req[w_cand[i]]) begin
                    o_idx = w_cand[i];
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_req[i]) begin
                    o_idx = GW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/servile_wb_arbiter_n.sv
// N-master to 1-slave Wishbone arbiter with registered grant, abort and timeout.
module servile_wb_arbiter_n
    import servile_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int RR          = 1,
    parameter int TIMEOUT     = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_MASTERS*AW-1:0]      i_wb_m_adr,
    input  logic [NUM_MASTERS*WB_DW-1:0]   i_wb_m_dat,
    input  logic [NUM_MASTERS*WB_SW-1:0]   i_wb_m_sel,
    input  logic [NUM_MASTERS-1:0]         i_wb_m_we,
    input  logic [NUM_MASTERS-1:0]         i_wb_m_stb,
    output logic [WB_DW-1:0]               o_wb_m_rdt,
    output logic [NUM_MASTERS-1:0]         o_wb_m_ack,
    output logic [NUM_MASTERS-1:0]         o_wb_m_err,
    output logic [AW-1:0]                  o_wb_mem_adr,
    output logic [WB_DW-1:0]               o_wb_mem_dat,
    output logic [WB_SW-1:0]               o_wb_mem_sel,
    output logic                           o_wb_mem_we,
    output logic                           o_wb_mem_stb,
    input  logic [WB_DW-1:0]               i_wb_mem_rdt,
    input  logic                           i_wb_mem_ack,
    output logic [clog2_min1(NUM_MASTERS)-1:0] o_grant
);

    localparam int GW = clog2_min1(NUM_MASTERS);
    localparam int CW = 16;

    arb_state_t    r_state, w_state_next;
    logic [GW-1:0] r_grant, w_grant_next;
    logic [GW-1:0] r_last,  w_last_next;
    logic [CW-1:0] r_cnt,   w_cnt_next;

    logic          w_pick_valid;
    logic [GW-1:0] w_pick_idx;
    logic          w_sel_stb;
    logic          w_tmo;
    logic          w_hit;

    // Per-master views of the flattened request buses.
    logic [AW-1:0]    w_adr [NUM_MASTERS];
    logic [WB_DW-1:0] w_dat [NUM_MASTERS];
    logic [WB_SW-1:0] w_sel [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
        assign w_adr[gi] = i_wb_m_adr[gi*AW +: AW];
        assign w_dat[gi] = i_wb_m_dat[gi*WB_DW +: WB_DW];
        assign w_sel[gi] = i_wb_m_sel[gi*WB_SW +: WB_SW];
    end

    servile_rr_picker #(
        .N  (NUM_MASTERS),
        .GW (GW)
    ) u_picker (
        .i_req   (i_wb_m_stb),
        .i_last  (r_last),
        .i_rr    (RR != 0),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Only the owner's request fields reach the slave; others are ignored.
    assign o_wb_mem_adr = w_adr[r_grant];
    assign o_wb_mem_dat = w_dat[r_grant];
    assign o_wb_mem_sel = w_sel[r_grant];
    assign o_wb_mem_we  = i_wb_m_we[r_grant];
    assign o_wb_m_rdt   = i_wb_mem_rdt;
    assign o_grant      = r_grant;
    assign w_sel_stb    = i_wb_m_stb[r_grant];

    // With TIMEOUT=0 the compare is constant-false and the counter is dead.
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    // Next-state and output decode; a transaction ends on ack, abort or timeout.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_cnt_next   = r_cnt;
        w_hit        = 1'b0;
        o_wb_mem_stb = 1'b0;
        o_wb_m_ack   = '0;
        o_wb_m_err   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_next = w_pick_idx;
                    w_cnt_next   = '0;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ack beats a coinciding timeout.
                w_hit                 = w_sel_stb && !i_wb_mem_ack && w_tmo;
                o_wb_mem_stb          = w_sel_stb && !w_hit;
                o_wb_m_ack[r_grant]   = i_wb_mem_ack;
                o_wb_m_err[r_grant]   = w_hit;
                if (i_wb_mem_ack || !w_sel_stb || w_hit) begin
                    w_last_next  = r_grant;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset leaves last owner at the top so master 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_MASTERS - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            r_cnt   <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_servile_wb_arbiter_n.sv
// Randomized scoreboard bench: a round-robin/timeout arbiter and a fixed-priority
// arbiter share the same master and slave stimulus, each with its own model.
module tb_servile_wb_arbiter_n;

    localparam int N    = 3;
    localparam int NCYC = 3000;

    typedef struct {
        int owner;   // -1 when no transaction is in progress
        int last;
        int cnt;
        int gnt;
    } mstate_t;

    typedef struct {
        int          cyc;
        logic        stb;
        logic [2:0]  ack;
        logic [2:0]  err;
        logic [1:0]  gnt;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdt;
        logic [3:0]  sel;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [95:0] m_adr, m_dat;
    logic [11:0] m_sel;
    logic [2:0]  m_we, m_stb;
    logic [31:0] mem_rdt;
    logic        mem_ack;

    logic [31:0] rdt0, rdt1, madr0, madr1, mdat0, mdat1;
    logic [2:0]  ack0, ack1, err0, err1;
    logic [3:0]  msel0, msel1;
    logic        mwe0, mwe1, mstb0, mstb1;
    logic [1:0]  gnt0, gnt1;

    servile_wb_arbiter_n #(.NUM_MASTERS(N), .AW(32), .RR(1), .TIMEOUT(4)) dut_rr (
        .i_clk(clk), .i_rst(rst),
        .i_wb_m_adr(m_adr), .i_wb_m_dat(m_dat), .i_wb_m_sel(m_sel),
        .i_wb_m_we(m_we), .i_wb_m_stb(m_stb),
        .o_wb_m_rdt(rdt0), .o_wb_m_ack(ack0), .o_wb_m_err(err0),
        .o_wb_mem_adr(madr0), .o_wb_mem_dat(mdat0), .o_wb_mem_sel(msel0),
        .o_wb_mem_we(mwe0), .o_wb_mem_stb(mstb0),
        .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack), .o_grant(gnt0)
    );

    servile_wb_arbiter_n #(.NUM_MASTERS(N), .AW(32), .RR(0), .TIMEOUT(0)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_wb_m_adr(m_adr), .i_wb_m_dat(m_dat), .i_wb_m_sel(m_sel),
        .i_wb_m_we(m_we), .i_wb_m_stb(m_stb),
        .o_wb_m_rdt(rdt1), .o_wb_m_ack(ack1), .o_wb_m_err(err1),
        .o_wb_mem_adr(madr1), .o_wb_mem_dat(mdat1), .o_wb_mem_sel(msel1),
        .o_wb_mem_we(mwe1), .o_wb_mem_stb(mstb1),
        .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack), .o_grant(gnt1)
    );

    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = -1;
    bit      running  = 1'b0;
    exp_t    q0[$];
    exp_t    q1[$];
    mstate_t s0, s1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    task automatic new_req(input int k);
        m_adr[k*32 +: 32] = $urandom;
        m_dat[k*32 +: 32] = $urandom;
        m_sel[k*4 +: 4]   = 4'($urandom_range(1, 15));
        m_we[k]           = 1'($urandom_range(0, 1));
    endtask

    // Reference behaviour of one arbiter for the current cycle's inputs,
    // followed by the ownership change that the coming clock edge makes.
    task automatic model_step(input bit rr, input int tmo, inout mstate_t s,
                              output exp_t e, output bit active);
        int  g;
        int  w;
        bit  hit;
        e.cyc = cyc;
        e.stb = 1'b0;
        e.ack = '0;
        e.err = '0;
        e.gnt = 2'(s.gnt);
        e.adr = '0;
        e.dat = '0;
        e.sel = '0;
        e.we  = 1'b0;
        e.rdt = mem_rdt;
        hit   = 1'b0;
        g     = s.owner;
        if (g >= 0) begin
            hit   = (tmo > 0) && m_stb[g] && !mem_ack && (s.cnt == tmo - 1);
            e.stb = m_stb[g] && !hit;
            e.ack[g] = mem_ack;
            e.err[g] = hit;
            e.adr = m_adr[g*32 +: 32];
            e.dat = m_dat[g*32 +: 32];
            e.sel = m_sel[g*4 +: 4];
            e.we  = m_we[g];
        end
        active = e.stb || (e.ack != 0) || (e.err != 0);
        if (rst) begin
            s = '{-1, N - 1, 0, 0};
        end else if (g < 0) begin
            w = -1;
            for (int k = N; k >= 1; k--) begin
                int c;
                c = rr ? (s.last + k) % N : k - 1;
                if (m_stb[c]) w = c;
            end
            if (w >= 0) begin
                s.owner = w;
                s.gnt   = w;
                s.cnt   = 0;
            end
        end else if (mem_ack || !m_stb[g] || hit) begin
            s.last  = g;
            s.owner = -1;
        end else begin
            s.cnt = s.cnt + 1;
        end
    endtask

    task automatic cmp_rec(input string tag, input exp_t e, input exp_t a);
        chk({tag, ".stb"}, 64'(a.stb), 64'(e.stb));
        chk({tag, ".ack"}, 64'(a.ack), 64'(e.ack));
        chk({tag, ".err"}, 64'(a.err), 64'(e.err));
        chk({tag, ".grant"}, 64'(a.gnt), 64'(e.gnt));
        if (e.stb) begin
            chk({tag, ".adr"}, 64'(a.adr), 64'(e.adr));
            chk({tag, ".dat"}, 64'(a.dat), 64'(e.dat));
            chk({tag, ".sel"}, 64'(a.sel), 64'(e.sel));
            chk({tag, ".we"},  64'(a.we),  64'(e.we));
        end
        if (e.ack != 0) begin
            chk({tag, ".rdt"}, 64'(a.rdt), 64'(e.rdt));
        end
    endtask

    // Monitor: pops an expectation whenever a DUT shows bus activity, and
    // flags expectations that the DUT never presented.
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        if (running) begin
            a = '{cyc, mstb0, ack0, err0, gnt0, madr0, mdat0, rdt0, msel0, mwe0};
            if (a.stb || (a.ack != 0) || (a.err != 0)) begin
                if (q0.size() == 0) begin
                    chk("rr.unexpected_activity", {a.stb, a.ack, a.err}, 64'd0);
                end else begin
                    e = q0.pop_front();
                    cmp_rec("rr", e, a);
                end
            end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
                e = q0.pop_front();
                chk("rr.missing_activity", {a.stb, a.ack, a.err}, {e.stb, e.ack, e.err});
            end
            a = '{cyc, mstb1, ack1, err1, gnt1, madr1, mdat1, rdt1, msel1, mwe1};
            if (a.stb || (a.ack != 0) || (a.err != 0)) begin
                if (q1.size() == 0) begin
                    chk("fp.unexpected_activity", {a.stb, a.ack, a.err}, 64'd0);
                end else begin
                    e = q1.pop_front();
                    cmp_rec("fp", e, a);
                end
            end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
                e = q1.pop_front();
                chk("fp.missing_activity", {a.stb, a.ack, a.err}, {e.stb, e.ack, e.err});
            end
        end
    end

    // Driver: random masters and slave, with one reset landing mid-transaction.
    initial begin
        exp_t       e0, e1;
        bit         a0, a1;
        logic [2:0] done_v;
        bit         rst_done;
        bit         post_rst;
        rst      = 1'b1;
        m_adr    = '0;
        m_dat    = '0;
        m_sel    = '0;
        m_we     = '0;
        m_stb    = '0;
        mem_rdt  = '0;
        mem_ack  = 1'b0;
        done_v   = '0;
        rst_done = 1'b0;
        post_rst = 1'b0;
        s0 = '{-1, N - 1, 0, 0};
        s1 = '{-1, N - 1, 0, 0};
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rr.stb",   64'(mstb0), 64'd0);
        chk("reset.rr.ack",   64'(ack0),  64'd0);
        chk("reset.rr.err",   64'(err0),  64'd0);
        chk("reset.rr.grant", 64'(gnt0),  64'd0);
        chk("reset.fp.stb",   64'(mstb1), 64'd0);
        chk("reset.fp.ack",   64'(ack1),  64'd0);
        chk("reset.fp.grant", 64'(gnt1),  64'd0);
        rst     = 1'b0;
        running = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (post_rst) begin
                chk("mid_reset.rr.stb",   64'(mstb0), 64'd0);
                chk("mid_reset.rr.grant", 64'(gnt0),  64'd0);
                post_rst = 1'b0;
            end
            cyc = c;
            for (int k = 0; k < N; k++) begin
                if (done_v[k]) begin
                    m_stb[k] = 1'($urandom_range(0, 1));
                    if (m_stb[k]) new_req(k);
                end else if (!m_stb[k]) begin
                    if ($urandom_range(0, 99) < 40) begin
                        m_stb[k] = 1'b1;
                        new_req(k);
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    m_stb[k] = 1'b0;
                end
            end
            mem_ack = (s0.owner >= 0) ? ($urandom_range(0, 99) < 30)
                                      : ($urandom_range(0, 99) < 10);
            mem_rdt = $urandom;
            rst     = 1'b0;
            if (c >= 1500 && !rst_done && s0.owner >= 0) begin
                rst      = 1'b1;
                rst_done = 1'b1;
                post_rst = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (!m_stb[k]) new_req(k);
                end
                m_stb = 3'b111;
            end
            model_step(1'b1, 4, s0, e0, a0);
            if (a0) q0.push_back(e0);
            model_step(1'b0, 0, s1, e1, a1);
            if (a1) q1.push_back(e1);
            done_v = rst ? 3'b000 : (e0.ack | e0.err);
        end
        @(negedge clk);
        #1;
        running = 1'b0;
        chk("rr.queue_drained", 64'(q0.size()), 64'd0);
        chk("fp.queue_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
